// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with a one-pixel address-to-colour pipeline.
// Optional 8-bar test pattern enabled by defining VGA_TEST_PATTERN_EN (adds TEST_MODE input).
module vga_timing_gen #(
  parameter int COLOUR_W = 12,
  parameter int CLK_DIV  = 4,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 29,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int H_CNT_W  = 10,
  parameter int V_CNT_W  = 10,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic                CLK,
  input  logic                RESET,
`ifdef VGA_TEST_PATTERN_EN
  input  logic                TEST_MODE,
`endif
  input  logic [COLOUR_W-1:0] COLOUR_IN,
  output logic                PIX_EN,
  output logic [H_CNT_W-1:0]  ADDRESS_H,
  output logic [V_CNT_W-1:0]  ADDRESS_V,
  output logic [COLOUR_W-1:0] COLOUR_OUT,
  output logic                SYNC_H,
  output logic                SYNC_V,
  output logic                DISP_EN,
  output logic                LINE_START,
  output logic                FRAME_START
);

  localparam int unsigned H_TOT    = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int unsigned V_TOT    = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int unsigned H_SYN_HI = H_SYNC;
  localparam int unsigned V_SYN_HI = V_SYNC;
  localparam int unsigned H_ACT_LO = H_SYNC + H_BP;
  localparam int unsigned H_ACT_HI = H_SYNC + H_BP + H_ACTIVE;
  localparam int unsigned V_ACT_LO = V_SYNC + V_BP;
  localparam int unsigned V_ACT_HI = V_SYNC + V_BP + V_ACTIVE;
  localparam int unsigned DIV_MAX  = CLK_DIV - 1;
  localparam int          DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  if (H_TOT > 2**H_CNT_W) begin : g_h_tot_chk
    $error("vga_timing_gen: H_TOT does not fit in H_CNT_W bits");
  end
  if (V_TOT > 2**V_CNT_W) begin : g_v_tot_chk
    $error("vga_timing_gen: V_TOT does not fit in V_CNT_W bits");
  end

  logic [DIV_W-1:0]    div_q, div_d;
  logic                pix_en_q, pix_en_d;
  logic [H_CNT_W-1:0]  h_cnt_q, h_cnt_d;
  logic [V_CNT_W-1:0]  v_cnt_q, v_cnt_d;
  logic                line_start_q, line_start_d;
  logic                frame_start_q, frame_start_d;
  logic                de_a_q, de_a_d;
  logic                hs_a_q, hs_a_d;
  logic                vs_a_q, vs_a_d;
  logic [H_CNT_W-1:0]  addr_h_q, addr_h_d;
  logic [V_CNT_W-1:0]  addr_v_q, addr_v_d;
  logic [COLOUR_W-1:0] colour_q, colour_d;
  logic                sync_h_q, sync_h_d;
  logic                sync_v_q, sync_v_d;
  logic                de_q, de_d;
  logic [COLOUR_W-1:0] colour_src;
  logic                h_last, v_last, h_act, v_act, h_sync, v_sync;

`ifdef VGA_TEST_PATTERN_EN
  localparam int unsigned BAR_PX = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
  localparam int          FW     = COLOUR_W / 3;
  logic [31:0]         bar_full;
  logic [2:0]          bar;
  logic [COLOUR_W-1:0] pattern;

  // addr_h_q still holds the address of the pixel being emitted in stage B
  always_comb begin
    bar_full = 32'(addr_h_q) / BAR_PX;
    bar      = (bar_full > 32'd7) ? 3'd7 : bar_full[2:0];
    pattern  = '0;
    pattern[COLOUR_W-1 -: FW]      = {FW{bar[2]}};
    pattern[COLOUR_W-1-FW -: FW]   = {FW{bar[1]}};
    pattern[COLOUR_W-1-2*FW -: FW] = {FW{bar[0]}};
    colour_src = TEST_MODE ? pattern : COLOUR_IN;
  end
`else
  always_comb colour_src = COLOUR_IN;
`endif

  always_comb begin
    h_last = (32'(h_cnt_q) == H_TOT - 1);
    v_last = (32'(v_cnt_q) == V_TOT - 1);
    h_sync = (32'(h_cnt_q) < H_SYN_HI);
    v_sync = (32'(v_cnt_q) < V_SYN_HI);
    h_act  = (32'(h_cnt_q) >= H_ACT_LO) && (32'(h_cnt_q) < H_ACT_HI);
    v_act  = (32'(v_cnt_q) >= V_ACT_LO) && (32'(v_cnt_q) < V_ACT_HI);

    pix_en_d      = (32'(div_q) == DIV_MAX);
    div_d         = pix_en_d ? '0 : div_q + DIV_W'(1);
    line_start_d  = pix_en_q && h_last;
    frame_start_d = pix_en_q && h_last && v_last;

    h_cnt_d  = h_cnt_q;
    v_cnt_d  = v_cnt_q;
    de_a_d   = de_a_q;
    hs_a_d   = hs_a_q;
    vs_a_d   = vs_a_q;
    addr_h_d = addr_h_q;
    addr_v_d = addr_v_q;
    colour_d = colour_q;
    sync_h_d = sync_h_q;
    sync_v_d = sync_v_q;
    de_d     = de_q;

    if (pix_en_q) begin
      h_cnt_d = h_last ? '0 : h_cnt_q + H_CNT_W'(1);
      if (h_last) v_cnt_d = v_last ? '0 : v_cnt_q + V_CNT_W'(1);

      de_a_d   = h_act && v_act;
      addr_h_d = h_act ? h_cnt_q - H_CNT_W'(H_ACT_LO) : '0;
      addr_v_d = v_act ? v_cnt_q - V_CNT_W'(V_ACT_LO) : '0;
      hs_a_d   = h_sync ? SYNC_POL : ~SYNC_POL;
      vs_a_d   = v_sync ? SYNC_POL : ~SYNC_POL;

      colour_d = de_a_q ? colour_src : '0;
      sync_h_d = hs_a_q;
      sync_v_d = vs_a_q;
      de_d     = de_a_q;
    end
  end

  // Stage-A sync registers reset deasserted so the first stage-B load cannot pulse sync
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      div_q         <= '0;
      pix_en_q      <= 1'b0;
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      de_a_q        <= 1'b0;
      hs_a_q        <= ~SYNC_POL;
      vs_a_q        <= ~SYNC_POL;
      addr_h_q      <= '0;
      addr_v_q      <= '0;
      colour_q      <= '0;
      sync_h_q      <= ~SYNC_POL;
      sync_v_q      <= ~SYNC_POL;
      de_q          <= 1'b0;
    end else begin
      div_q         <= div_d;
      pix_en_q      <= pix_en_d;
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      de_a_q        <= de_a_d;
      hs_a_q        <= hs_a_d;
      vs_a_q        <= vs_a_d;
      addr_h_q      <= addr_h_d;
      addr_v_q      <= addr_v_d;
      colour_q      <= colour_d;
      sync_h_q      <= sync_h_d;
      sync_v_q      <= sync_v_d;
      de_q          <= de_d;
    end
  end

  assign PIX_EN      = pix_en_q;
  assign ADDRESS_H   = addr_h_q;
  assign ADDRESS_V   = addr_v_q;
  assign COLOUR_OUT  = colour_q;
  assign SYNC_H      = sync_h_q;
  assign SYNC_V      = sync_v_q;
  assign DISP_EN     = de_q;
  assign LINE_START  = line_start_q;
  assign FRAME_START = frame_start_q;

endmodule
